// File: rtl/pkt_framer_tx.sv
// pkt_framer_tx
// Turns packet descriptors (a word count) into a stream of framed words.
// Each packet gets an 8-bit id that increments after every completed packet.
// Every word carries {pkt_id, word_idx}.
//
// Ports
//   clk             sole clock, rising edge
//   reset           synchronous, active-high
//   cfg_port_enable 1 = new descriptors may be accepted
//   req_val/req_len descriptor handshake and packet length in words
//   req_ready       descriptor accepted when req_val & req_ready
//   tx_ready        downstream accepts a word when val & tx_ready
//   val/sop/eop     word valid, first word, last word
//   data            {pkt_id[7:0], word_idx[7:0]}
//   len_err         one-cycle pulse after a zero-length descriptor is accepted
//   busy            high while a packet is being sent
//   pkt_cnt         completed packets, saturating at 0xFFFF
module pkt_framer_tx #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_port_enable,
    input  logic             req_val,
    input  logic [LEN_W-1:0] req_len,
    output logic             req_ready,
    input  logic             tx_ready,
    output logic             val,
    output logic             sop,
    output logic             eop,
    output logic [15:0]      data,
    output logic             len_err,
    output logic             busy,
    output logic [15:0]      pkt_cnt
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t           state;
    logic [7:0]       pkt_id;
    logic [LEN_W-1:0] word_idx;
    // Words still to send after the one currently presented.
    logic [LEN_W-1:0] words_left;

    logic             xfer;
    logic             last_xfer;
    logic             accept;
    logic             len_zero;
    logic [7:0]       start_id;
    logic [LEN_W-1:0] idx_inc;
    logic [7:0]       idx_inc_lo;

    assign xfer      = val & tx_ready;
    assign last_xfer = xfer & eop;

    // A new descriptor is taken in IDLE, or in the same cycle the final word
    // leaves. The second case gives back-to-back packets with no idle gap.
    assign req_ready = ~reset & cfg_port_enable &
                       ((state == IDLE) | ((state == SEND) & last_xfer));
    assign accept    = req_val & req_ready;
    assign len_zero  = (req_len == '0);

    // A packet started in the same cycle as an eop transfer must already use
    // the incremented id.
    assign start_id  = last_xfer ? (pkt_id + 8'd1) : pkt_id;
    assign idx_inc   = word_idx + LEN_W'(1);
    assign busy      = (state == SEND);

    generate
        if (LEN_W >= 8) begin : g_idx_wide
            assign idx_inc_lo = idx_inc[7:0];
        end else begin : g_idx_narrow
            assign idx_inc_lo = {{(8 - LEN_W){1'b0}}, idx_inc};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            val        <= 1'b0;
            sop        <= 1'b0;
            eop        <= 1'b0;
            data       <= 16'h0000;
            len_err    <= 1'b0;
            pkt_cnt    <= 16'h0000;
            pkt_id     <= 8'h00;
            word_idx   <= '0;
            words_left <= '0;
        end else begin
            len_err <= accept & len_zero;

            if (last_xfer) begin
                pkt_id <= pkt_id + 8'd1;
                if (pkt_cnt != 16'hFFFF) begin
                    pkt_cnt <= pkt_cnt + 16'd1;
                end
            end

            if (accept && !len_zero) begin
                state      <= SEND;
                val        <= 1'b1;
                sop        <= 1'b1;
                eop        <= (req_len == LEN_W'(1));
                data       <= {start_id, 8'h00};
                word_idx   <= '0;
                words_left <= req_len - LEN_W'(1);
            end else if (last_xfer) begin
                state      <= IDLE;
                val        <= 1'b0;
                sop        <= 1'b0;
                eop        <= 1'b0;
                data       <= 16'h0000;
                word_idx   <= '0;
                words_left <= '0;
            end else if (xfer) begin
                // The next word is last when exactly one word remains.
                sop        <= 1'b0;
                eop        <= (words_left == LEN_W'(1));
                data       <= {pkt_id, idx_inc_lo};
                word_idx   <= idx_inc;
                words_left <= words_left - LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pkt_framer_tx.sv
// tb_pkt_framer_tx
// Scoreboard bench for pkt_framer_tx. Each accepted descriptor pushes its
// expected words onto a queue. The monitor compares the head of that queue
// with every valid word and pops the head when the word transfers.
module tb_pkt_framer_tx;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cfg_port_enable = 1'b1;
    logic             req_val = 1'b0;
    logic [LEN_W-1:0] req_len = '0;
    logic             tx_ready = 1'b1;
    logic             req_ready;
    logic             val;
    logic             sop;
    logic             eop;
    logic [15:0]      data;
    logic             len_err;
    logic             busy;
    logic [15:0]      pkt_cnt;

    int errors = 0;
    int checks = 0;

    // Entry layout: {sop, eop, data[15:0]}
    logic [17:0] exp_q[$];
    logic [17:0] head;
    logic [7:0]  model_id = 8'h00;
    logic [15:0] model_cnt = 16'h0000;
    logic        exp_len_err = 1'b0;
    bit          armed = 1'b0;
    bit          acc;

    pkt_framer_tx #(.LEN_W(LEN_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .cfg_port_enable (cfg_port_enable),
        .req_val         (req_val),
        .req_len         (req_len),
        .req_ready       (req_ready),
        .tx_ready        (tx_ready),
        .val             (val),
        .sop             (sop),
        .eop             (eop),
        .data            (data),
        .len_err         (len_err),
        .busy            (busy),
        .pkt_cnt         (pkt_cnt)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    // Present a descriptor, hold it until it is accepted, then withdraw it.
    task automatic applyStimulus(input int len);
        bit done = 1'b0;
        req_val = 1'b1;
        req_len = LEN_W'(len);
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (req_ready) done = 1'b1;
        end
        @(posedge clk);
        #1 req_val = 1'b0;
        if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Check all outputs on the falling edge, clear of the active edge. The
    // expected req_ready uses the head of the queue: the open packet is on
    // its last word exactly when one entry remains.
    always @(negedge clk) begin
        if (reset) begin
            checkOutput("rdy_in_reset", {31'd0, req_ready}, 32'd0);
            exp_q.delete();
            model_id    = 8'h00;
            model_cnt   = 16'h0000;
            exp_len_err = 1'b0;
            armed       = 1'b1;
        end else if (armed) begin
            checkOutput("val", {31'd0, val}, {31'd0, exp_q.size() != 0});
            checkOutput("busy", {31'd0, busy}, {31'd0, exp_q.size() != 0});
            checkOutput("pkt_cnt", {16'd0, pkt_cnt}, {16'd0, model_cnt});
            checkOutput("len_err", {31'd0, len_err}, {31'd0, exp_len_err});
            checkOutput("req_ready", {31'd0, req_ready},
                        {31'd0, cfg_port_enable &&
                         (exp_q.size() == 0 || (exp_q.size() == 1 && tx_ready))});
            if (val && exp_q.size() != 0) begin
                checkOutput("word", {14'd0, sop, eop, data}, {14'd0, exp_q[0]});
                if (tx_ready) begin
                    head = exp_q.pop_front();
                    if (head[16] && model_cnt != 16'hFFFF) model_cnt++;
                end
            end
            exp_len_err = req_val && req_ready && (req_len == 0);
            if (req_val && req_ready && req_len != 0) begin
                for (int i = 0; i < int'(req_len); i++) begin
                    exp_q.push_back({i == 0, i == int'(req_len) - 1, model_id, 8'(i)});
                end
                model_id++;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit drained;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Three-word packet straight after reset.
        applyStimulus(3);
        idleCycles(4);

        // Two single-word packets; the second uses id 1.
        doReset();
        applyStimulus(1);
        applyStimulus(1);
        idleCycles(3);

        // A zero-length descriptor, then a packet that still uses id 0.
        doReset();
        applyStimulus(0);
        applyStimulus(1);
        idleCycles(3);

        // Stall word 1 of a four-word packet for two cycles.
        doReset();
        applyStimulus(4);
        @(posedge clk);
        #1 tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 tx_ready = 1'b1;
        idleCycles(6);

        // Back-to-back two-word packets with req_val held.
        doReset();
        req_val = 1'b1;
        req_len = LEN_W'(2);
        repeat (3) @(posedge clk);
        #1 req_val = 1'b0;
        idleCycles(4);

        // Drop the enable after the first word; the packet still completes.
        applyStimulus(3);
        @(posedge clk);
        #1 cfg_port_enable = 1'b0;
        req_val = 1'b1;
        req_len = LEN_W'(2);
        repeat (6) @(posedge clk);
        #1 cfg_port_enable = 1'b1;
        @(posedge clk);
        #1 req_val = 1'b0;
        idleCycles(4);

        // Reset in the middle of a five-word packet.
        applyStimulus(5);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        idleCycles(2);
        applyStimulus(1);
        idleCycles(3);

        // Single-word packets back to back, enough to wrap the id.
        req_val = 1'b1;
        req_len = LEN_W'(1);
        repeat (260) @(posedge clk);
        #1 req_val = 1'b0;
        idleCycles(3);

        // Random lengths and random downstream back-pressure.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            acc = req_val && req_ready;
            @(posedge clk);
            #1;
            tx_ready = ($urandom_range(0, 3) != 0);
            if (acc || !req_val) begin
                req_val = ($urandom_range(0, 1) == 1);
                req_len = LEN_W'($urandom_range(0, 5));
            end
        end
        req_val  = 1'b0;
        tx_ready = 1'b1;

        drained = 1'b0;
        for (int c = 0; c < 100 && !drained; c++) begin
            @(posedge clk);
            if (exp_q.size() == 0) drained = 1'b1;
        end
        if (!drained) checkOutput("drain_timeout", 32'd0, 32'd1);
        idleCycles(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
